// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_pkg                                                      |
// | Purpose  : Shared encodings for the RV32 pipeline hazard controller.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_W     = 2'd1;
    localparam logic [1:0] FWD_M_ALU = 2'd2;
    localparam logic [1:0] FWD_M_LUI = 2'd3;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl_if                                         |
// | Purpose  : Datapath <-> hazard controller bundle (master = datapath).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if;

    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       regWriteM;
    logic       regWriteW;
    logic [1:0] resultSrcE;
    logic       luiM;
    logic [1:0] PCSrcE;
    logic       mcStartE;

    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       mcBusy;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output regWriteM, regWriteW, resultSrcE, luiM, PCSrcE, mcStartE,
        input  forwardAE, forwardBE, stallF, stallD, stallE,
        input  flushD, flushE, flushM, mcBusy
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  regWriteM, regWriteW, resultSrcE, luiM, PCSrcE, mcStartE,
        output forwardAE, forwardBE, stallF, stallD, stallE,
        output flushD, flushE, flushM, mcBusy
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : forward_sel                                                     |
// | Purpose  : EX operand forward select for one source register.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module forward_sel
    import hazard_pkg::*;
(
    input  wire logic [4:0] RsE,
    input  wire logic [4:0] RdM,
    input  wire logic [4:0] RdW,
    input  wire logic       regWriteM,
    input  wire logic       regWriteW,
    input  wire logic       luiM,
    output logic      [1:0] sel
);

    logic w_rs_nonzero;

    assign w_rs_nonzero = (RsE != 5'd0);

    // The youngest producer (M) shadows an older write of the same register in W.
    always_comb begin
        sel = FWD_RF;
        if (w_rs_nonzero && regWriteM && (RsE == RdM)) begin
            sel = luiM ? FWD_M_LUI : FWD_M_ALU;
        end else if (w_rs_nonzero && regWriteW && (RsE == RdW)) begin
            sel = FWD_W;
        end
    end

endmodule : forward_sel
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                            |
// | Purpose  : Forwarding, load-use and multi-cycle EX hold control for the    |
// |            5-stage RV32 pipeline. HAZARD_PERF_CNT_EN adds stall/flush      |
// |            performance counters.                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stallCycles,
    output logic [31:0]           flushCount
`endif
);

    localparam bit               C_MC_MULTI = (MC_CYCLES >= 2);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'((MC_CYCLES >= 2) ? (MC_CYCLES - 2) : 0);

    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_lw_stall;
    logic             w_mc_stall;
    logic             w_taken;
    mc_state_t        r_state;
    mc_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    forward_sel u_fwd_a (
        .RsE       (hz.Rs1E),
        .RdM       (hz.RdM),
        .RdW       (hz.RdW),
        .regWriteM (hz.regWriteM),
        .regWriteW (hz.regWriteW),
        .luiM      (hz.luiM),
        .sel       (w_fwd_a)
    );

    forward_sel u_fwd_b (
        .RsE       (hz.Rs2E),
        .RdM       (hz.RdM),
        .RdW       (hz.RdW),
        .regWriteM (hz.regWriteM),
        .regWriteW (hz.regWriteW),
        .luiM      (hz.luiM),
        .sel       (w_fwd_b)
    );

    assign w_lw_stall = (hz.resultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The first EX cycle stalls from IDLE so the unit can latch operands while
    // M/W forwarding is still valid; cnt then counts the remaining held cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mc_stall  = 1'b0;
        case (r_state)
            IDLE: begin
                if (hz.mcStartE && C_MC_MULTI) begin
                    w_mc_stall  = 1'b1;
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = C_CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_mc_stall = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A branch resolved by an op still held in EX is not real yet, so mask it.
    assign w_taken = (hz.PCSrcE != 2'b00) && !w_mc_stall;

    assign hz.forwardAE = w_fwd_a;
    assign hz.forwardBE = w_fwd_b;
    assign hz.stallF    = w_lw_stall | w_mc_stall;
    assign hz.stallD    = w_lw_stall | w_mc_stall;
    assign hz.stallE    = w_mc_stall;
    assign hz.flushM    = w_mc_stall;
    assign hz.flushD    = w_taken;
    assign hz.flushE    = w_taken | (w_lw_stall & !w_mc_stall);
    assign hz.mcBusy    = (r_state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_lw_stall | w_mc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_taken | (w_lw_stall & !w_mc_stall)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stallCycles = r_stall_cycles;
    assign flushCount  = r_flush_count;
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipeline_hazard_ctrl                                         |
// | Purpose  : Directed plus random bench for pipeline_hazard_ctrl against an  |
// |            occupancy-based reference model. Honours HAZARD_PERF_CNT_EN.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

    localparam int MC_CYCLES = 4;
    localparam int CNT_W     = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles;
    logic [31:0] flushCount;
`endif

    pipeline_hazard_ctrl #(
        .MC_CYCLES (MC_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCycles (stallCycles),
        .flushCount  (flushCount)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index of the EX cycle the held op is in (-1 = none held)
    int          m_k = -1;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;
    int          e_k_now;
    bit          e_mc_stall;
    bit          e_stall_d;
    bit          e_flush_any;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic wm,
                                           input logic ww, input logic lui);
        if (rs == 5'd0)              return 2'd0;
        if (wm && rs == rdm)         return lui ? 2'd3 : 2'd2;
        if (ww && rs == rdw)         return 2'd1;
        return 2'd0;
    endfunction

    task automatic clear_inputs();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.regWriteM = 0; hz.regWriteW = 0; hz.resultSrcE = 0;
        hz.luiM = 0; hz.PCSrcE = 0; hz.mcStartE = 0;
    endtask

    // Settle at the falling edge and compare every output with the model.
    task automatic eval_cycle();
        bit lw;
        bit tk;
        @(negedge clk);
        e_k_now    = (m_k >= 0) ? m_k : (hz.mcStartE ? 0 : -1);
        e_mc_stall = (e_k_now >= 0) && (e_k_now < MC_CYCLES - 1);
        lw = (hz.resultSrcE == 2'b01) && (hz.RdE != 0) &&
             ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        tk = (hz.PCSrcE != 0) && !e_mc_stall;
        e_stall_d   = lw || e_mc_stall;
        e_flush_any = tk || (lw && !e_mc_stall);
        check_val("forwardAE", 32'(hz.forwardAE),
                  32'(fwd_ref(hz.Rs1E, hz.RdM, hz.RdW, hz.regWriteM, hz.regWriteW, hz.luiM)));
        check_val("forwardBE", 32'(hz.forwardBE),
                  32'(fwd_ref(hz.Rs2E, hz.RdM, hz.RdW, hz.regWriteM, hz.regWriteW, hz.luiM)));
        check_val("stallF", 32'(hz.stallF), 32'(e_stall_d));
        check_val("stallD", 32'(hz.stallD), 32'(e_stall_d));
        check_val("stallE", 32'(hz.stallE), 32'(e_mc_stall));
        check_val("flushM", 32'(hz.flushM), 32'(e_mc_stall));
        check_val("flushD", 32'(hz.flushD), 32'(tk));
        check_val("flushE", 32'(hz.flushE), 32'(tk || (lw && !e_mc_stall)));
        check_val("mcBusy", 32'(hz.mcBusy), 32'(m_k >= 0));
`ifdef HAZARD_PERF_CNT_EN
        check_val("stallCycles", stallCycles, m_stall_cnt);
        check_val("flushCount", flushCount, m_flush_cnt);
`endif
    endtask

    task automatic next_edge();
        if (rst) begin
            m_k         = -1;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            m_k = e_mc_stall ? (e_k_now + 1) : -1;
            if (e_stall_d)   m_stall_cnt = m_stall_cnt + 1;
            if (e_flush_any) m_flush_cnt = m_flush_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle();
        eval_cycle();
        next_edge();
    endtask

    initial begin
        bit exp_stall[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bit exp_busy[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_k = -1; m_stall_cnt = '0; m_flush_cnt = '0;
        // Reset state with rst still high
        run_cycle();
        check_val("reset_mcBusy", 32'(hz.mcBusy), 32'd0);
        rst = 1'b0;

        // Forwarding priorities
        hz.Rs1E = 5; hz.RdM = 5; hz.regWriteM = 1; hz.RdW = 5; hz.regWriteW = 1;
        eval_cycle(); check_val("fwd_m_alu", 32'(hz.forwardAE), 32'd2); next_edge();
        hz.luiM = 1;
        eval_cycle(); check_val("fwd_m_lui", 32'(hz.forwardAE), 32'd3); next_edge();
        hz.Rs1E = 0; hz.RdM = 0; hz.RdW = 0;
        eval_cycle(); check_val("fwd_x0", 32'(hz.forwardAE), 32'd0); next_edge();
        clear_inputs();

        // Load-use: one stall, then bubble in E, then forward from W
        hz.resultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
        eval_cycle();
        check_val("lw_stallD", 32'(hz.stallD), 32'd1);
        check_val("lw_flushE", 32'(hz.flushE), 32'd1);
        next_edge();
        clear_inputs(); hz.Rs2D = 7; hz.RdM = 7; hz.regWriteM = 1;
        run_cycle();
        clear_inputs(); hz.Rs2E = 7; hz.RdW = 7; hz.regWriteW = 1;
        eval_cycle(); check_val("lw_fwd_w", 32'(hz.forwardBE), 32'd1); next_edge();
        clear_inputs();

        // Multi-cycle hold; a redirect inside the hold is masked
        for (int c = 0; c < 4; c++) begin
            hz.mcStartE = 1;
            hz.PCSrcE   = (c == 1) ? 2'b01 : 2'b00;
            eval_cycle();
            check_val("mc_stallE", 32'(hz.stallE), 32'(exp_stall[c]));
            check_val("mc_busy", 32'(hz.mcBusy), 32'(exp_busy[c]));
            if (c == 1) check_val("mc_mask_flushD", 32'(hz.flushD), 32'd0);
            next_edge();
        end
        clear_inputs();
        eval_cycle();
        check_val("mc_release_busy", 32'(hz.mcBusy), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_val("perf_stall", stallCycles, 32'd4);
        check_val("perf_flush", flushCount, 32'd1);
`endif
        next_edge();

        // Redirect together with load-use
        hz.PCSrcE = 2'b01; hz.resultSrcE = 2'b01; hz.RdE = 3; hz.Rs1D = 3;
        eval_cycle();
        check_val("br_lw_flushD", 32'(hz.flushD), 32'd1);
        check_val("br_lw_stallF", 32'(hz.stallF), 32'd1);
        next_edge();
        clear_inputs();

        // Reset in the second BUSY cycle aborts the op
        hz.mcStartE = 1;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0; hz.mcStartE = 0;
        eval_cycle();
        check_val("rst_abort_busy", 32'(hz.mcBusy), 32'd0);
        check_val("rst_abort_stallE", 32'(hz.stallE), 32'd0);
        next_edge();

        // Randomized traffic on a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
            hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
            hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
            hz.RdW  = 5'($urandom_range(0, 3));
            hz.regWriteM  = 1'($urandom);  hz.regWriteW = 1'($urandom);
            hz.resultSrcE = 2'($urandom);  hz.luiM      = 1'($urandom);
            hz.PCSrcE     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            hz.mcStartE   = (m_k >= 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            rst           = ($urandom_range(0, 39) == 0);
            run_cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
